// File: rtl/div3_word_serializer.sv
// div3_word_serializer: clears an external divide-by-3 residue FSM, feeds it a word MSB-first
// and reports its verdict. Define DIV3_SELF_CHECK_EN to add an internal modulo cross-check.
module div3_word_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 6
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             rem_in,
    output logic             serial_bit,
    output logic             fsm_clr,
    output logic             busy,
    output logic             done,
    output logic             divisible,
    output logic [WIDTH-1:0] result_word,
    output logic             chk_err
);

    typedef enum logic [1:0] {StIdle, StClr, StShift, StCheck} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             serial_bit_d;
    logic             fsm_clr_d;
    logic             busy_d;
    logic             done_d;
    logic             divisible_d;
    logic [WIDTH-1:0] result_word_d;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StClr;
            StClr:   state_d = StShift;
            StShift: if (cnt_q == LastCnt) state_d = StCheck;
            StCheck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // word_q keeps the accepted word intact while sreg_q is shifted out
    always_comb begin
        sreg_d = sreg_q;
        word_d = word_q;
        cnt_d  = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sreg_d = din;
                    word_d = din;
                    cnt_d  = '0;
                end
            end
            StShift: begin
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            sreg_q <= '0;
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // Outputs are registered, so they are derived from the upcoming state
    always_comb begin
        serial_bit_d  = (state_d == StShift) ? sreg_d[WIDTH-1] : 1'b0;
        fsm_clr_d     = (state_d == StClr);
        busy_d        = (state_d != StIdle);
        done_d        = (state_q == StCheck);
        divisible_d   = divisible;
        result_word_d = result_word;
        if (state_q == StCheck) begin
            divisible_d   = rem_in;
            result_word_d = word_q;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            serial_bit  <= 1'b0;
            fsm_clr     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            divisible   <= 1'b0;
            result_word <= '0;
        end else begin
            serial_bit  <= serial_bit_d;
            fsm_clr     <= fsm_clr_d;
            busy        <= busy_d;
            done        <= done_d;
            divisible   <= divisible_d;
            result_word <= result_word_d;
        end
    end

`ifdef DIV3_SELF_CHECK_EN
    logic ref_q;
    logic chk_err_q;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            ref_q     <= 1'b0;
            chk_err_q <= 1'b0;
        end else begin
            if (state_q == StIdle && start) begin
                ref_q <= ((din % WIDTH'(3)) == '0);
            end
            if (state_q == StCheck && rem_in != ref_q) begin
                chk_err_q <= 1'b1;
            end
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_div3_word_serializer.sv
// Bench for div3_word_serializer: two lanes (WIDTH 8 and 5), each with a behavioural residue FSM,
// a scoreboard queue fed on acceptance and a per-cycle monitor.
module tb_div3_word_serializer;

    localparam int NL = 2;

    logic              Clk = 1'b0;
    logic              reset;
    logic [NL-1:0]     start_s;
    logic [NL-1:0]     force0;
    logic [31:0]       din_s [NL];
    wire  [NL-1:0]     done_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int lane, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     lane, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int W = (g == 0) ? 8 : 5;
        localparam logic [31:0] MASK = (32'd1 << W) - 32'd1;

        typedef struct {
            logic [31:0] word;
            int          acc;
            logic        forced;
        } exp_t;

        exp_t q[$];
        int          cyc = 0;
        int          free_at = 0;
        int          r = 0;
        logic [31:0] last_word = 0;
        logic        last_div = 1'b0;
        logic        chk_exp = 1'b0;

        logic         serial_bit, fsm_clr, busy, done, divisible, chk_err, rem_in;
        logic [W-1:0] result_word;

        // Behavioural residue FSM: running value mod 3, cleared by reset or fsm_clr
        always @(posedge Clk or posedge reset) begin
            if (reset) r <= 0;
            else if (fsm_clr) r <= 0;
            else r <= (2 * r + int'(serial_bit)) % 3;
        end

        assign rem_in    = force0[g] ? 1'b0 : (r == 0);
        assign done_w[g] = done;

        div3_word_serializer #(
            .WIDTH(W),
            .CNT_W(6)
        ) dut (
            .Clk        (Clk),
            .reset      (reset),
            .start      (start_s[g]),
            .din        (din_s[g][W-1:0]),
            .rem_in     (rem_in),
            .serial_bit (serial_bit),
            .fsm_clr    (fsm_clr),
            .busy       (busy),
            .done       (done),
            .divisible  (divisible),
            .result_word(result_word),
            .chk_err    (chk_err)
        );

        // Acceptance model: a start is taken when the block is free again
        always @(posedge Clk) begin
            cyc++;
            if (!reset && start_s[g] && cyc >= free_at) begin
                q.push_back('{word: din_s[g] & MASK, acc: cyc, forced: force0[g]});
                free_at = cyc + W + 3;
            end
        end

        always @(negedge Clk) begin : mon
            logic exp_done, exp_clr, exp_bit;
            int   k;
            exp_done = 1'b0;
            exp_clr  = 1'b0;
            exp_bit  = 1'b0;
            if (reset) begin
                q.delete();
                free_at   = 0;
                last_word = 0;
                last_div  = 1'b0;
                chk_exp   = 1'b0;
            end else if (q.size() != 0) begin
                k = cyc - q[0].acc;
                if (k == W + 2) begin
                    exp_done  = 1'b1;
                    last_word = q[0].word;
                    last_div  = !q[0].forced && (q[0].word % 3 == 0);
`ifdef DIV3_SELF_CHECK_EN
                    if (q[0].forced && (q[0].word % 3 == 0)) chk_exp = 1'b1;
`endif
                    void'(q.pop_front());
                end else begin
                    exp_clr = (k == 0);
                    if (k >= 1 && k <= W) exp_bit = q[0].word[W-k];
                end
            end
            check("done", g, done, exp_done);
            check("fsm_clr", g, fsm_clr, exp_clr);
            check("serial_bit", g, serial_bit, exp_bit);
            check("busy", g, busy, q.size() != 0);
            check("divisible", g, divisible, last_div);
            check("result_word", g, result_word, last_word);
            check("chk_err", g, chk_err, chk_exp);
        end
    end

    task automatic wait_done(input int l);
        int n = 0;
        while (n < 64 && !done_w[l]) begin
            @(negedge Clk);
            n++;
        end
        check("done_seen", l, done_w[l], 1'b1);
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input int l, input logic [31:0] w, input logic frc);
        force0[l]  = frc;
        din_s[l]   = w;
        start_s[l] = 1'b1;
        @(posedge Clk);
        #1;
        start_s[l] = 1'b0;
        din_s[l]   = $urandom;
        wait_done(l);
        force0[l] = 1'b0;
    endtask

    // Random start pulses and din changes while busy must be ignored
    task automatic send_noisy(input int l, input int w_bits, input logic [31:0] w);
        din_s[l]   = w;
        start_s[l] = 1'b1;
        @(posedge Clk);
        #1;
        for (int j = 0; j < w_bits + 1; j++) begin
            start_s[l] = 1'($urandom_range(0, 1));
            din_s[l]   = $urandom;
            @(posedge Clk);
            #1;
        end
        start_s[l] = 1'b0;
        wait_done(l);
        repeat ($urandom_range(0, 3)) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // start held high: words a, b, c accepted every 11 cycles on the WIDTH=8 lane
    task automatic held(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [31:0] ws [3];
        ws[0] = a;
        ws[1] = b;
        ws[2] = c;
        start_s[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_s[0] = ws[i];
            @(posedge Clk);
            #1;
            if (i < 2) begin
                for (int j = 0; j < 10; j++) begin
                    din_s[0] = $urandom;
                    @(posedge Clk);
                    #1;
                end
            end
        end
        start_s[0] = 1'b0;
        wait_done(0);
    endtask

    task automatic abort_run(input logic [31:0] w);
        din_s[0]   = w;
        start_s[0] = 1'b1;
        @(posedge Clk);
        #1;
        start_s[0] = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        reset = 1'b1;
        @(posedge Clk);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge Clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        start_s  = '0;
        force0   = '0;
        din_s[0] = 0;
        din_s[1] = 0;
        repeat (3) @(posedge Clk);
        #1;
        reset = 1'b0;
        @(posedge Clk);
        #1;

        send(0, 32'd9, 1'b0);
        send(0, 32'd10, 1'b0);
        send(0, 32'd0, 1'b0);
        send(0, 32'd255, 1'b0);
        send(0, 32'd254, 1'b0);
        held(32'd3, 32'd4, 32'd5);
        abort_run($urandom & 32'hff);
        send(0, 32'd6, 1'b0);
        send(0, 32'd9, 1'b1);
        send(0, 32'd9, 1'b0);
        send(0, 32'd12, 1'b0);
        send(1, 32'd30, 1'b0);

        for (int i = 0; i < 12; i++) begin
            send_noisy(0, 8, $urandom);
            send_noisy(1, 5, $urandom);
        end

        check("queue_drained", 0, lane[0].q.size(), 0);
        check("queue_drained", 1, lane[1].q.size(), 0);

        reset = 1'b1;
        @(posedge Clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div3_word_serializer.md
Name: div3_word_serializer

Overview:
- Upstream feeder for the serial divide-by-3 residue FSM.
- Accepts a parallel WIDTH-bit word on a start strobe and shifts it out MSB-first, one bit per Clk, on serial_bit. serial_bit drives the FSM's Datain.
- Clears the FSM before each word, then samples the FSM's REM flag after the last bit.
- Returns a one-cycle done pulse with a divisible-by-3 verdict. Software-facing logic sees a simple word-in/result-out handshake.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- CNT_W, 6: bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clock Clk.
- start  input  1  request; samples din when the block is idle.
- din  input  WIDTH  word to test.
- rem_in  input  1  REM from the residue FSM; 1 means running value mod 3 == 0.
- serial_bit  output  1  bit stream to FSM Datain, MSB first.
- fsm_clr  output  1  registered clear for the FSM; integrator ORs it into the FSM reset.
- busy  output  1  high from the accepting edge until done.
- done  output  1  one-cycle pulse; result valid.
- divisible  output  1  verdict; holds until the next done.
- result_word  output  WIDTH  word the verdict refers to; holds until the next done.
- chk_err  output  1  sticky self-check error; see Optional Feature.

Behaviour:
- All outputs are registered. Reset values: serial_bit=0, fsm_clr=0, busy=0, done=0, divisible=0, result_word=0, chk_err=0. Internal state is IDLE.
- States: IDLE, CLR, SHIFT, CHECK. Shift register sreg[WIDTH-1:0], bit counter cnt[CNT_W-1:0].
- IDLE:
  - On start=1 at an edge: sreg<=din, result_word is NOT yet updated, cnt<=0, fsm_clr<=1, busy<=1, go to CLR.
  - Otherwise stay in IDLE.
- CLR (one cycle):
  - fsm_clr=1 and serial_bit=0. Because the bit is 0, the FSM stays in S0 whether or not it leaves reset at the next edge, so reset recovery timing is tolerated.
  - Next edge: fsm_clr<=0, go to SHIFT.
- SHIFT:
  - serial_bit = sreg[WIDTH-1] throughout.
  - Each edge: sreg<=sreg<<1 and cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge: the last bit has been consumed; go to CHECK.
  - SHIFT lasts exactly WIDTH cycles.
- CHECK (one cycle):
  - serial_bit=0; rem_in now reflects the full word.
  - Next edge: divisible<=rem_in, result_word<=latched word, done<=1, busy<=0, go to IDLE.
- serial_bit is forced to 0 in every state except SHIFT.
- Latency: from the edge that accepts start to the edge that raises done is WIDTH+2 edges (10 for WIDTH=8).
- Throughput: one word per WIDTH+3 cycles. A start sampled in the same cycle that done is high is accepted.
- start while busy=1 is ignored and not queued. din is sampled only at the accepting edge.
- done is high for exactly one cycle and is never asserted without a preceding accepted start.
- reset mid-operation: immediate return to IDLE with all outputs at reset values. The FSM is cleared by the same system reset. No done is produced for the aborted word.
- din=0 produces divisible=1 (0 mod 3 == 0).

Optional Feature:
- Macro: DIV3_SELF_CHECK_EN.
- Defined:
  - At the accepting edge, compute ref = (din % 3 == 0) into a register.
  - At the done edge, if rem_in != ref, set chk_err<=1.
  - chk_err is sticky until reset. This catches wiring or timing faults with the external FSM.
- Undefined: no modulo logic is synthesised and chk_err is tied to 0. All other behaviour is identical.

Test Plan:
- WIDTH=8, reset, then start with din=8'd9 -> fsm_clr high for 1 cycle; serial_bit sequence 0,0,0,0,1,0,0,1; done exactly 10 edges after the accepting edge; divisible=1, result_word=9.
- din=8'd10 -> divisible=0; din=8'd0 -> divisible=1; din=8'd255 -> divisible=1; din=8'd254 -> divisible=0. chk_err stays 0 with the macro defined.
- start held high continuously with words 3, 4, 5 -> three done pulses spaced 11 cycles apart; verdicts 1, 0, 0; start pulses during busy do not change result_word.
- Assert reset for 1 cycle during the 4th SHIFT cycle -> all outputs return to 0 asynchronously; no done; the next start with din=8'd6 gives divisible=1.
- Macro defined, rem_in forced to 0 for the din=8'd9 run -> divisible=0 and chk_err=1, remaining 1 through subsequent correct runs until reset.
- WIDTH=5, din=5'd30 -> serial_bit sequence 1,1,1,1,0; done 7 edges after acceptance; divisible=1.
